// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush/enable generation, data-memory stall and halt drain FSM.
// Enables and flushes are combinational in state and inputs; state and stall counter are registered.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  input  logic        dmem_done,
  input  logic        ex_mem_MemEn,
  input  logic        id_ex_MemEn,
  input  logic        id_ex_MemWr,
  input  logic        id_ex_RegWriteEN,
  input  logic [2:0]  id_ex_dst_reg_num,
  input  logic [2:0]  if_id_rs,
  input  logic        if_id_rs_valid,
  input  logic [2:0]  if_id_rt,
  input  logic        if_id_rt_valid,
  input  logic        branch_taken,
  input  logic        halt_in,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DSTALL = 2'b01,
    DRAIN  = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_stall_cnt;
  logic        w_rs_hit;
  logic        w_rt_hit;
  logic        w_load_use;
  logic        w_dmem_hold;
  logic        w_count;

  assign w_rs_hit    = if_id_rs_valid && (if_id_rs == id_ex_dst_reg_num);
  assign w_rt_hit    = if_id_rt_valid && (if_id_rt == id_ex_dst_reg_num);
  assign w_load_use  = id_ex_MemEn && !id_ex_MemWr && id_ex_RegWriteEN && (w_rs_hit || w_rt_hit);
  assign w_dmem_hold = dmem_stall && ex_mem_MemEn;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;
    w_next       = r_state;

    case (r_state)
      RUN: begin
        // Priority order matters: halt beats a data stall, which beats all front-end hazards.
        if (halt_in) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          w_next    = DRAIN;
        end else if (w_dmem_hold) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
          w_next       = DSTALL;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (imem_stall) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end
      end
      DSTALL: begin
        // Front-end hazards are deliberately ignored on the release cycle.
        if (dmem_done) begin
          w_next = RUN;
        end else begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        w_next    = HALTED;
      end
      HALTED: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        halted    = 1'b1;
      end
      default: w_next = RUN;
    endcase

    if (!rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      halted       = 1'b0;
      w_next       = RUN;
    end
  end

  assign w_count = !pc_en && ((r_state == RUN) || (r_state == DSTALL)) && (r_stall_cnt != 16'hFFFF);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_stall_cnt <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_count) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus a randomized run against a table-driven reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_stall, dmem_stall, dmem_done, ex_mem_MemEn;
  logic        id_ex_MemEn, id_ex_MemWr, id_ex_RegWriteEN;
  logic [2:0]  id_ex_dst_reg_num, if_id_rs, if_id_rt;
  logic        if_id_rs_valid, if_id_rt_valid, branch_taken, halt_in;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [7:0]  obs;

  int n_checks = 0;
  int n_fail   = 0;
  int m_state  = 0;
  int m_cnt    = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, mem_wb flushes}
  localparam logic [7:0] O_HALT   = 8'b00001_000;
  localparam logic [7:0] O_DSTALL = 8'b00001_001;
  localparam logic [7:0] O_BR     = 8'b11111_110;
  localparam logic [7:0] O_LU     = 8'b00111_010;
  localparam logic [7:0] O_IMEM   = 8'b01111_100;
  localparam logic [7:0] O_NORM   = 8'b11111_000;
  localparam logic [7:0] O_DRAIN  = 8'b00001_000;
  localparam logic [7:0] O_HALTED = 8'b00000_000;
  localparam logic [7:0] O_RST    = 8'b00000_111;

  always #5 clk = ~clk;

  assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush};

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .imem_stall(imem_stall), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .ex_mem_MemEn(ex_mem_MemEn), .id_ex_MemEn(id_ex_MemEn), .id_ex_MemWr(id_ex_MemWr),
    .id_ex_RegWriteEN(id_ex_RegWriteEN), .id_ex_dst_reg_num(id_ex_dst_reg_num),
    .if_id_rs(if_id_rs), .if_id_rs_valid(if_id_rs_valid), .if_id_rt(if_id_rt),
    .if_id_rt_valid(if_id_rt_valid), .branch_taken(branch_taken), .halt_in(halt_in),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .halted(halted), .state(state), .stall_cnt(stall_cnt)
  );

  function automatic logic model_load_use();
    return id_ex_MemEn && !id_ex_MemWr && id_ex_RegWriteEN &&
           ((if_id_rs_valid && if_id_rs == id_ex_dst_reg_num) ||
            (if_id_rt_valid && if_id_rt == id_ex_dst_reg_num));
  endfunction

  // Behaviour table: which situation applies now, and what the pipeline must see for it.
  function automatic logic [7:0] exp_vec();
    if (!rst) return O_RST;
    case (m_state)
      0: begin
        if (halt_in)                     return O_HALT;
        if (dmem_stall && ex_mem_MemEn)  return O_DSTALL;
        if (branch_taken)                return O_BR;
        if (model_load_use())            return O_LU;
        if (imem_stall)                  return O_IMEM;
        return O_NORM;
      end
      1:       return dmem_done ? O_NORM : O_DSTALL;
      2:       return O_DRAIN;
      default: return O_HALTED;
    endcase
  endfunction

  function automatic int exp_next();
    if (!rst) return 0;
    case (m_state)
      0:       return halt_in ? 2 : ((dmem_stall && ex_mem_MemEn) ? 1 : 0);
      1:       return dmem_done ? 0 : 1;
      default: return 3;
    endcase
  endfunction

  // Advance one clock: update model from current inputs, leave time at the following negedge.
  task automatic step();
    logic [7:0] e;
    int nx;
    e  = exp_vec();
    nx = exp_next();
    if (!rst) m_cnt = 0;
    else if (!e[7] && m_state < 2) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    @(posedge clk);
    m_state = nx;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_stall = 0; dmem_stall = 0; dmem_done = 0; ex_mem_MemEn = 0;
    id_ex_MemEn = 0; id_ex_MemWr = 0; id_ex_RegWriteEN = 0; id_ex_dst_reg_num = 0;
    if_id_rs = 0; if_id_rs_valid = 0; if_id_rt = 0; if_id_rt_valid = 0;
    branch_taken = 0; halt_in = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0; halt_in = 1; dmem_stall = 1; ex_mem_MemEn = 1;
    #1;
    n_checks++;
    if (obs !== O_RST) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, O_RST); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
    step(); step();
    n_checks++;
    if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
    n_checks++;
    if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0000", stall_cnt); end
    rst = 1; idle_inputs();
    #1;
    n_checks++;
    if (obs !== O_NORM) begin n_fail++; $display("FAIL reset_release: got %b expected %b", obs, O_NORM); end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    id_ex_MemEn = 1; id_ex_RegWriteEN = 1; id_ex_dst_reg_num = 3'd3;
    if_id_rs = 3'd3; if_id_rs_valid = 1;
    #1;
    n_checks++;
    if (obs !== O_LU) begin n_fail++; $display("FAIL load_use_rs: got %b expected %b", obs, O_LU); end
    step();
    n_checks++;
    if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt: got %h expected 0001", stall_cnt); end
    idle_inputs();
    #1;
    n_checks++;
    if (obs !== O_NORM) begin n_fail++; $display("FAIL load_use_after: got %b expected %b", obs, O_NORM); end
    // rs matches but is not read; rt is a real match
    id_ex_MemEn = 1; id_ex_RegWriteEN = 1; id_ex_dst_reg_num = 3'd5;
    if_id_rs = 3'd5; if_id_rs_valid = 0; if_id_rt = 3'd5; if_id_rt_valid = 1;
    #1;
    n_checks++;
    if (obs !== O_LU) begin n_fail++; $display("FAIL load_use_rt: got %b expected %b", obs, O_LU); end
    if_id_rt_valid = 0;
    #1;
    n_checks++;
    if (obs !== O_NORM) begin n_fail++; $display("FAIL load_use_invalid: got %b expected %b", obs, O_NORM); end
    if_id_rt_valid = 1; id_ex_MemWr = 1;
    #1;
    n_checks++;
    if (obs !== O_NORM) begin n_fail++; $display("FAIL load_use_store: got %b expected %b", obs, O_NORM); end
    step();
    n_checks++;
    if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt2: got %h expected 0001", stall_cnt); end
  endtask

  task automatic test_dstall();
    do_reset();
    ex_mem_MemEn = 1; dmem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (obs !== O_DSTALL) begin n_fail++; $display("FAIL dstall_out[%0d]: got %b expected %b", i, obs, O_DSTALL); end
      step();
      n_checks++;
      if (state !== 2'b01) begin n_fail++; $display("FAIL dstall_state[%0d]: got %b expected 01", i, state); end
    end
    // release cycle: front-end hazards must not take effect
    dmem_done = 1; dmem_stall = 0; branch_taken = 1; imem_stall = 1;
    #1;
    n_checks++;
    if (obs !== O_NORM) begin n_fail++; $display("FAIL dstall_done_out: got %b expected %b", obs, O_NORM); end
    step();
    n_checks++;
    if (state !== 2'b00) begin n_fail++; $display("FAIL dstall_done_state: got %b expected 00", state); end
    n_checks++;
    if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL dstall_cnt: got %h expected 0003", stall_cnt); end
  endtask

  task automatic test_branch_lu();
    do_reset();
    branch_taken = 1; imem_stall = 1;
    id_ex_MemEn = 1; id_ex_RegWriteEN = 1; id_ex_dst_reg_num = 3'd2; if_id_rt = 3'd2; if_id_rt_valid = 1;
    #1;
    n_checks++;
    if (obs !== O_BR) begin n_fail++; $display("FAIL branch_lu_out: got %b expected %b", obs, O_BR); end
    step();
    n_checks++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL branch_lu_cnt: got %h expected 0000", stall_cnt); end
    idle_inputs(); imem_stall = 1;
    #1;
    n_checks++;
    if (obs !== O_IMEM) begin n_fail++; $display("FAIL imem_out: got %b expected %b", obs, O_IMEM); end
    step();
    n_checks++;
    if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL imem_cnt: got %h expected 0001", stall_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    halt_in = 1; dmem_stall = 1; ex_mem_MemEn = 1;
    #1;
    n_checks++;
    if (obs !== O_HALT) begin n_fail++; $display("FAIL halt_out: got %b expected %b", obs, O_HALT); end
    step();
    idle_inputs();
    n_checks++;
    if (state !== 2'b10) begin n_fail++; $display("FAIL halt_drain_state: got %b expected 10", state); end
    #1;
    n_checks++;
    if (obs !== O_DRAIN || halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_drain_out: got %b/%b expected %b/0", obs, halted, O_DRAIN);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      {imem_stall, dmem_stall, dmem_done, ex_mem_MemEn, branch_taken, halt_in} = 6'($urandom);
      #1;
      n_checks++;
      if (state !== 2'b11 || halted !== 1'b1 || obs !== O_HALTED) begin
        n_fail++; $display("FAIL halted[%0d]: got state %b halted %b out %b expected 11/1/%b", i, state, halted, obs, O_HALTED);
      end
      step();
    end
    n_checks++;
    if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL halt_cnt: got %h expected 0001", stall_cnt); end
  endtask

  task automatic test_reset_mid_dstall();
    do_reset();
    ex_mem_MemEn = 1; dmem_stall = 1;
    step(); step();
    n_checks++;
    if (state !== 2'b01 || stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL mid_dstall_setup: got %b/%h expected 01/0002", state, stall_cnt);
    end
    rst = 0;
    #1;
    n_checks++;
    if (obs !== O_RST || halted !== 1'b0) begin
      n_fail++; $display("FAIL mid_dstall_forced: got %b/%b expected %b/0", obs, halted, O_RST);
    end
    step();
    rst = 1; idle_inputs();
    n_checks++;
    if (state !== 2'b00 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_dstall_reset: got %b/%h expected 00/0000", state, stall_cnt);
    end
    #1;
    n_checks++;
    if (obs !== O_NORM) begin n_fail++; $display("FAIL mid_dstall_run: got %b expected %b", obs, O_NORM); end
    step();
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst               = ($urandom_range(0, 49) != 0);
      halt_in           = ($urandom_range(0, 59) == 0);
      imem_stall        = 1'($urandom);
      dmem_stall        = 1'($urandom);
      dmem_done         = ($urandom_range(0, 2) == 0);
      ex_mem_MemEn      = 1'($urandom);
      id_ex_MemEn       = 1'($urandom);
      id_ex_MemWr       = 1'($urandom);
      id_ex_RegWriteEN  = 1'($urandom);
      id_ex_dst_reg_num = 3'($urandom);
      if_id_rs          = 3'($urandom);
      if_id_rt          = 3'($urandom);
      if_id_rs_valid    = 1'($urandom);
      if_id_rt_valid    = 1'($urandom);
      branch_taken      = ($urandom_range(0, 3) == 0);
      if (m_state == 3 && $urandom_range(0, 4) == 0) rst = 0;
      #1;
      n_checks++;
      if (obs !== exp_vec() || halted !== (m_state == 3 && rst)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL random_out[%0d]: got %b/%b expected %b/%b", i, obs, halted, exp_vec(), (m_state == 3 && rst));
      end
      step();
      n_checks++;
      if (state !== 2'(m_state) || stall_cnt !== 16'(m_cnt)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL random_state[%0d]: got %b/%h expected %b/%h", i, state, stall_cnt, 2'(m_state), 16'(m_cnt));
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_stall = 1;
    for (int i = 0; i < 65534; i++) step();
    n_checks++;
    if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h expected fffe", stall_cnt); end
    step();
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", stall_cnt); end
    step(); step();
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", stall_cnt); end
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_dstall();
    test_branch_lu();
    test_halt();
    test_reset_mid_dstall();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
